// File: rtl/if_bus_master_if.sv
// rtl/if_bus_master_if.sv - Wishbone read-only instruction fetch bus bundle
//
// Signals:
//   wbm_adr_o  32  address, driven by master
//   wbm_cyc_o   1  bus cycle, driven by master
//   wbm_stb_o   1  strobe, driven by master, mirrors wbm_cyc_o
//   wbm_sel_o   4  byte select, driven by master, all lanes enabled
//   wbm_dat_i  32  read data, driven by slave
//   wbm_ack_i   1  acknowledge, driven by slave
//   wbm_err_i   1  bus error, driven by slave
// Modports: master (fetch unit side), slave (memory side).

interface if_bus_master_if;
    logic [31:0] wbm_adr_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    modport master (
        output wbm_adr_o,
        output wbm_cyc_o,
        output wbm_stb_o,
        output wbm_sel_o,
        input  wbm_dat_i,
        input  wbm_ack_i,
        input  wbm_err_i
    );

    modport slave (
        input  wbm_adr_o,
        input  wbm_cyc_o,
        input  wbm_stb_o,
        input  wbm_sel_o,
        output wbm_dat_i,
        output wbm_ack_i,
        output wbm_err_i
    );
endinterface

// File: rtl/if_bus_master.sv
// rtl/if_bus_master.sv - instruction fetch Wishbone master for the IF stage
//
// Parameters:
//   NOP_INSTR       instruction word presented when no valid fetch data exists
//   TIMEOUT_CYCLES  BUSY cycles without ack/err before an access fault is forced (1..255)
//
// Ports:
//   clk_i         system clock, all state on the rising edge
//   rst_i         synchronous active-high reset
//   pc_i          fetch address from the PC register
//   pipe_stall_i  downstream hazard, IF/ID does not capture this cycle
//   flush_i       PC redirect, any in-flight fetch is stale
//   bus           Wishbone master bundle (registered adr/cyc/stb, constant sel)
//   instr_o       instruction to the IF stage
//   stall_o       no instruction delivered this cycle
//   exc_addr_o    instruction-address-misaligned flag (IDLE only)
//   exc_fault_o   instruction-access-fault flag, one cycle (BUSY only)

module if_bus_master #(
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [31:0]             pc_i,
    input  logic                    pipe_stall_i,
    input  logic                    flush_i,
    if_bus_master_if.master         bus,
    output logic [31:0]             instr_o,
    output logic                    stall_o,
    output logic                    exc_addr_o,
    output logic                    exc_fault_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        KILL = 2'd3
    } state_t;

    // Watchdog fires while the counter shows the last allowed cycle, so the
    // fault is reported in exactly the TIMEOUT_CYCLES-th BUSY cycle.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic        cyc_q, cyc_d;
    logic [31:0] buffer_q, buffer_d;
    logic [7:0]  count_q, count_d;

    logic        timeout;
    logic        pc_misaligned;

    assign timeout       = (count_q == TIMEOUT_LAST);
    assign pc_misaligned = (pc_i[1:0] != 2'b00);

    assign bus.wbm_adr_o = adr_q;
    assign bus.wbm_cyc_o = cyc_q;
    assign bus.wbm_stb_o = cyc_q;
    assign bus.wbm_sel_o = 4'b1111;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // Abandons any open bus cycle; a late ack lands in IDLE and is ignored.
            state_q  <= IDLE;
            adr_q    <= 32'h0;
            cyc_q    <= 1'b0;
            buffer_q <= NOP_INSTR;
            count_q  <= 8'h0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            cyc_q    <= cyc_d;
            buffer_q <= buffer_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        cyc_d       = cyc_q;
        buffer_d    = buffer_q;
        count_d     = count_q;
        instr_o     = NOP_INSTR;
        stall_o     = 1'b1;
        exc_addr_o  = 1'b0;
        exc_fault_o = 1'b0;

        case (state_q)
            IDLE: begin
                if (flush_i) begin
                    // Redirect wins: the PC on the bus this cycle is already stale.
                    stall_o = 1'b1;
                end else if (pc_misaligned) begin
                    // Deliver a NOP alongside the exception so the pipeline can trap.
                    exc_addr_o = 1'b1;
                    stall_o    = 1'b0;
                end else begin
                    adr_d   = pc_i;
                    cyc_d   = 1'b1;
                    count_d = 8'h0;
                    state_d = BUSY;
                    stall_o = 1'b1;
                end
            end

            BUSY: begin
                if (flush_i) begin
                    stall_o = 1'b1;
                    if (bus.wbm_ack_i || bus.wbm_err_i) begin
                        // The bus cycle ends now; the returned data is dropped.
                        cyc_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        // Keep the cycle open until the slave terminates it.
                        count_d = count_q + 8'd1;
                        state_d = KILL;
                    end
                end else if (bus.wbm_err_i || (!bus.wbm_ack_i && timeout)) begin
                    exc_fault_o = 1'b1;
                    stall_o     = 1'b0;
                    cyc_d       = 1'b0;
                    state_d     = IDLE;
                end else if (bus.wbm_ack_i) begin
                    instr_o = bus.wbm_dat_i;
                    stall_o = 1'b0;
                    cyc_d   = 1'b0;
                    if (pipe_stall_i) begin
                        // IF/ID is not capturing: park the word until it is taken.
                        buffer_d = bus.wbm_dat_i;
                        state_d  = DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    count_d = count_q + 8'd1;
                end
            end

            DONE: begin
                instr_o = buffer_q;
                stall_o = 1'b0;
                if (!pipe_stall_i || flush_i) begin
                    state_d = IDLE;
                end
            end

            KILL: begin
                stall_o = 1'b1;
                if (bus.wbm_ack_i || bus.wbm_err_i || timeout) begin
                    cyc_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    count_d = count_q + 8'd1;
                end
            end

            default: begin
                cyc_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_if_bus_master.sv
// tb/tb_if_bus_master.sv - self-checking bench for if_bus_master

module tb_if_bus_master;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_i;
    logic [31:0] pc_i;
    logic        pipe_stall_i;
    logic        flush_i;
    logic [31:0] instr_o;
    logic        stall_o;
    logic        exc_addr_o;
    logic        exc_fault_o;

    if_bus_master_if bus();

    if_bus_master #(
        .NOP_INSTR      (NOP),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .pc_i         (pc_i),
        .pipe_stall_i (pipe_stall_i),
        .flush_i      (flush_i),
        .bus          (bus),
        .instr_o      (instr_o),
        .stall_o      (stall_o),
        .exc_addr_o   (exc_addr_o),
        .exc_fault_o  (exc_fault_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] dat;
        int          waits;
        int          stalls;
        logic        use_err;
        logic        use_ack;
        logic [31:0] exp_instr;
        logic        exp_fault;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[8];

    int tests = 0;
    int fails = 0;
    int cyc_cnt = 0;
    int req_cycle = 0;
    int req_cycle_prev = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Runs one fetch from IDLE; returns just after the edge that re-enters IDLE.
    task automatic do_fetch(input logic [31:0] pc, input logic [31:0] dat, input int waits,
                            input int stalls, input logic use_err, input logic use_ack,
                            input logic [31:0] exp_instr, input logic exp_fault);
        exp_t e;
        pc_i = pc;
        flush_i = 1'b0;
        pipe_stall_i = 1'b0;
        bus.wbm_ack_i = 1'b0;
        bus.wbm_err_i = 1'b0;
        @(negedge clk);
        check("idle_stall", stall_o, 1'b1);
        check("idle_cyc", bus.wbm_cyc_o, 1'b0);
        @(posedge clk); #1;
        req_cycle_prev = req_cycle;
        req_cycle = cyc_cnt;
        check("req_cyc", bus.wbm_cyc_o, 1'b1);
        check("req_stb", bus.wbm_stb_o, 1'b1);
        check("req_adr", bus.wbm_adr_o, pc);
        check("req_sel", bus.wbm_sel_o, 4'hF);
        for (int i = 0; i < waits; i++) begin
            pc_i = pc + 32'h40;
            @(negedge clk);
            check("wait_stall", stall_o, 1'b1);
            check("wait_adr", bus.wbm_adr_o, pc);
            check("wait_fault", exc_fault_o, 1'b0);
            @(posedge clk); #1;
        end
        bus.wbm_dat_i = dat;
        bus.wbm_ack_i = use_ack;
        bus.wbm_err_i = use_err;
        pipe_stall_i = (stalls > 0);
        sb.push_back('{exp_instr, exp_fault});
        @(negedge clk);
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("resp_instr", instr_o, e.instr);
            check("resp_fault", exc_fault_o, e.fault);
            check("resp_stall", stall_o, 1'b0);
        end
        @(posedge clk); #1;
        bus.wbm_ack_i = 1'b0;
        bus.wbm_err_i = 1'b0;
        bus.wbm_dat_i = 32'hFFFF_FFFF;
        check("end_cyc", bus.wbm_cyc_o, 1'b0);
        for (int k = 1; k < stalls; k++) begin
            @(negedge clk);
            check("done_instr", instr_o, exp_instr);
            check("done_stall", stall_o, 1'b0);
            check("done_cyc", bus.wbm_cyc_o, 1'b0);
            @(posedge clk); #1;
        end
        if (stalls > 0) begin
            pipe_stall_i = 1'b0;
            @(negedge clk);
            check("done_last_instr", instr_o, exp_instr);
            check("done_last_stall", stall_o, 1'b0);
            @(posedge clk); #1;
            check("done_exit_cyc", bus.wbm_cyc_o, 1'b0);
        end
    endtask

    initial begin
        int n;
        logic found;

        vecs[0] = '{32'h100, 32'h0050_0093, 0, 0, 1'b0, 1'b1, 32'h0050_0093, 1'b0};
        vecs[1] = '{32'h104, 32'h00A0_0113, 0, 0, 1'b0, 1'b1, 32'h00A0_0113, 1'b0};
        vecs[2] = '{32'h108, 32'h1234_5678, 2, 0, 1'b0, 1'b1, 32'h1234_5678, 1'b0};
        vecs[3] = '{32'h10C, 32'hCAFE_F00D, 0, 4, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0};
        vecs[4] = '{32'h110, 32'h5555_AAAA, 1, 0, 1'b1, 1'b0, NOP,            1'b1};
        vecs[5] = '{32'h114, 32'h0BAD_F00D, 0, 0, 1'b1, 1'b1, NOP,            1'b1};
        vecs[6] = '{32'h118, 32'hA5A5_A5A5, 0, 1, 1'b0, 1'b1, 32'hA5A5_A5A5, 1'b0};
        vecs[7] = '{32'h11C, 32'h0000_0073, 3, 0, 1'b0, 1'b1, 32'h0000_0073, 1'b0};

        rst_i = 1'b1;
        pc_i = 32'h0;
        flush_i = 1'b1;
        pipe_stall_i = 1'b0;
        bus.wbm_dat_i = 32'h0;
        bus.wbm_ack_i = 1'b0;
        bus.wbm_err_i = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cyc", bus.wbm_cyc_o, 1'b0);
        check("rst_stb", bus.wbm_stb_o, 1'b0);
        check("rst_adr", bus.wbm_adr_o, 32'h0);
        check("rst_instr", instr_o, NOP);
        check("rst_fault", exc_fault_o, 1'b0);
        check("rst_sel", bus.wbm_sel_o, 4'hF);
        @(posedge clk); #1;
        rst_i = 1'b0;

        // Misaligned PC: no request, exception with NOP, no stall
        flush_i = 1'b0;
        pc_i = 32'h102;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mis_exc", exc_addr_o, 1'b1);
            check("mis_instr", instr_o, NOP);
            check("mis_stall", stall_o, 1'b0);
            check("mis_cyc", bus.wbm_cyc_o, 1'b0);
            @(posedge clk); #1;
        end

        // Table of fetches
        for (int i = 0; i < 8; i++) begin
            do_fetch(vecs[i].pc, vecs[i].dat, vecs[i].waits, vecs[i].stalls,
                     vecs[i].use_err, vecs[i].use_ack, vecs[i].exp_instr, vecs[i].exp_fault);
            if (i == 1) check("throughput", 32'(req_cycle - req_cycle_prev), 32'd2);
        end

        // Flush while pending, slave acks three cycles later
        pc_i = 32'h300;
        @(negedge clk);
        @(posedge clk); #1;
        flush_i = 1'b1;
        @(negedge clk);
        check("flush_stall", stall_o, 1'b1);
        check("flush_fault", exc_fault_o, 1'b0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        pc_i = 32'h400;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("kill_stall", stall_o, 1'b1);
            check("kill_cyc", bus.wbm_cyc_o, 1'b1);
            check("kill_adr", bus.wbm_adr_o, 32'h300);
            @(posedge clk); #1;
        end
        bus.wbm_dat_i = 32'hDEAD_BEEF;
        bus.wbm_ack_i = 1'b1;
        @(negedge clk);
        check("kill_ack_stall", stall_o, 1'b1);
        check("kill_ack_fault", exc_fault_o, 1'b0);
        @(posedge clk); #1;
        bus.wbm_ack_i = 1'b0;
        check("kill_end_cyc", bus.wbm_cyc_o, 1'b0);
        do_fetch(32'h400, 32'h0010_0093, 0, 0, 1'b0, 1'b1, 32'h0010_0093, 1'b0);

        // Flush coincident with ack: data dropped, no fault
        pc_i = 32'h600;
        @(negedge clk);
        @(posedge clk); #1;
        flush_i = 1'b1;
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = 32'h1111_1111;
        @(negedge clk);
        check("flush_ack_stall", stall_o, 1'b1);
        check("flush_ack_fault", exc_fault_o, 1'b0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        bus.wbm_ack_i = 1'b0;
        check("flush_ack_cyc", bus.wbm_cyc_o, 1'b0);
        do_fetch(32'h604, 32'h0020_0093, 0, 0, 1'b0, 1'b1, 32'h0020_0093, 1'b0);

        // Reset mid-transaction, late ack ignored
        pc_i = 32'h700;
        @(negedge clk);
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        check("rst_busy_cyc", bus.wbm_cyc_o, 1'b0);
        check("rst_busy_stb", bus.wbm_stb_o, 1'b0);
        check("rst_busy_adr", bus.wbm_adr_o, 32'h0);
        flush_i = 1'b1;
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = 32'h2222_2222;
        @(negedge clk);
        check("late_ack_fault", exc_fault_o, 1'b0);
        check("late_ack_exc", exc_addr_o, 1'b0);
        check("late_ack_instr", instr_o, NOP);
        @(posedge clk); #1;
        bus.wbm_ack_i = 1'b0;
        check("late_ack_cyc", bus.wbm_cyc_o, 1'b0);
        do_fetch(32'h704, 32'h0030_0093, 0, 0, 1'b0, 1'b1, 32'h0030_0093, 1'b0);

        // Watchdog timeout
        pc_i = 32'h800;
        @(negedge clk);
        @(posedge clk); #1;
        n = 0;
        found = 1'b0;
        for (int i = 1; i <= 300 && !found; i++) begin
            @(negedge clk);
            if (exc_fault_o) begin
                found = 1'b1;
                n = i;
                check("to_instr", instr_o, NOP);
                check("to_stall", stall_o, 1'b0);
            end else begin
                @(posedge clk); #1;
            end
        end
        check("to_found", found, 1'b1);
        check("to_cycle", n, 32'd255);
        @(posedge clk); #1;
        flush_i = 1'b1;
        check("to_cyc_drop", bus.wbm_cyc_o, 1'b0);
        @(negedge clk);
        check("to_pulse_once", exc_fault_o, 1'b0);
        @(posedge clk); #1;
        do_fetch(32'h900, 32'h0040_0093, 0, 0, 1'b0, 1'b1, 32'h0040_0093, 1'b0);

        check("sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
